// File: rtl/calc_pkg.sv
// Shared definitions for the calculator datapath and its keypad front end.
// Holds the operator key codes used by both the keypad scanner and the
// calculator control block, the scanner FSM state type, and small decode
// helpers for the 4x4 keypad matrix.
package calc_pkg;

    localparam logic [3:0] KEY_SOMA  = 4'b1010;
    localparam logic [3:0] KEY_SUB   = 4'b1011;
    localparam logic [3:0] KEY_STORE = 4'b1100;
    localparam logic [3:0] KEY_LOAD  = 4'b1101;
    localparam logic [3:0] KEY_ENTER = 4'b1110;
    localparam logic [3:0] KEY_CLR   = 4'b1111;

    typedef enum logic [1:0] {
        SCAN         = 2'd0,
        DEBOUNCE     = 2'd1,
        EMIT         = 2'd2,
        WAIT_RELEASE = 2'd3
    } scan_state_t;

    // Columns are active-low: a valid key shows exactly one low bit.
    // Returns {valid, column index}; several low bits count as no key.
    function automatic logic [2:0] col_decode(input logic [3:0] col);
        logic [2:0] res;
        case (col)
            4'b1110: res = {1'b1, 2'd0};
            4'b1101: res = {1'b1, 2'd1};
            4'b1011: res = {1'b1, 2'd2};
            4'b0111: res = {1'b1, 2'd3};
            default: res = {1'b0, 2'd0};
        endcase
        return res;
    endfunction

    // Column pattern seen on the bus when only column idx is pulled low.
    function automatic logic [3:0] col_pattern(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

    // Active-low one-cold row drive for row index idx.
    function automatic logic [3:0] row_drive(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

    // Physical key position to calculator key code.
    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'd0:    code = 4'b0001;
            4'd1:    code = 4'b0010;
            4'd2:    code = 4'b0011;
            4'd3:    code = KEY_SOMA;
            4'd4:    code = 4'b0100;
            4'd5:    code = 4'b0101;
            4'd6:    code = 4'b0110;
            4'd7:    code = KEY_SUB;
            4'd8:    code = 4'b0111;
            4'd9:    code = 4'b1000;
            4'd10:   code = 4'b1001;
            4'd11:   code = KEY_STORE;
            4'd12:   code = KEY_CLR;
            4'd13:   code = 4'b0000;
            4'd14:   code = KEY_ENTER;
            4'd15:   code = KEY_LOAD;
            default: code = 4'b0000;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a bus of independent, slowly changing bits.
// Ports: clk (sampling clock), reset (async active-low), d (asynchronous
// input), q (synchronized output, RESET_VAL while in reset).
module sync_2ff #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_r <= RESET_VAL;
            sync_r <= RESET_VAL;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner with press and release debouncing.
// Drives one row low at a time, samples the synchronized columns, debounces
// a single-key press, emits one tecla_valid pulse per press and waits for a
// clean release before resuming the scan.
// Ports: clk, reset (async active-low), col_in (active-low columns, async),
// row_out (one-cold row drive), tecla (last accepted key code),
// tecla_valid (one-cycle pulse with each new tecla).
module keypad_scanner
    import calc_pkg::*;
#(
    parameter int SCAN_CYCLES     = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic [3:0] tecla,
    output logic       tecla_valid
);

    localparam int CNT_TOP = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
    localparam int CW      = $clog2(CNT_TOP + 1);

    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_CYCLES);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_SAT   = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};

    logic [3:0]  col_s;
    scan_state_t state_r, state_nxt_s;
    logic [CW-1:0] cnt_r, cnt_nxt_s, cnt_inc_s;
    logic [1:0]  row_r, row_nxt_s;
    logic [1:0]  col_idx_r, col_idx_nxt_s;
    logic [2:0]  col_dec_s;
    logic [3:0]  row_out_r;
    logic [3:0]  tecla_r;
    logic        tecla_valid_r;

    sync_2ff #(
        .WIDTH     (4),
        .RESET_VAL (4'b1111)
    ) u_col_sync (
        .clk   (clk),
        .reset (reset),
        .d     (col_in),
        .q     (col_s)
    );

    assign col_dec_s = col_decode(col_s);
    // The counter holds at all-ones instead of wrapping.
    assign cnt_inc_s = (cnt_r == CNT_SAT) ? cnt_r : cnt_r + CW'(1);

    // Next-state logic. Each state counts first and acts on the edge after
    // the count has reached its target, which puts the pulse exactly
    // DEBOUNCE_CYCLES+1 cycles after the scan sample.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        row_nxt_s     = row_r;
        col_idx_nxt_s = col_idx_r;
        case (state_r)
            SCAN: begin
                if (cnt_r == SCAN_LAST) begin
                    cnt_nxt_s = CNT_ZERO;
                    if (col_dec_s[2]) begin
                        col_idx_nxt_s = col_dec_s[1:0];
                        state_nxt_s   = DEBOUNCE;
                    end else begin
                        row_nxt_s = row_r + 2'd1;
                    end
                end else begin
                    cnt_nxt_s = cnt_inc_s;
                end
            end
            DEBOUNCE: begin
                if (cnt_r == DEB_LAST) begin
                    cnt_nxt_s   = CNT_ZERO;
                    state_nxt_s = EMIT;
                end else if (col_s == col_pattern(col_idx_r)) begin
                    cnt_nxt_s = cnt_inc_s;
                end else begin
                    cnt_nxt_s   = CNT_ZERO;
                    row_nxt_s   = row_r + 2'd1;
                    state_nxt_s = SCAN;
                end
            end
            EMIT: begin
                cnt_nxt_s   = CNT_ZERO;
                state_nxt_s = WAIT_RELEASE;
            end
            WAIT_RELEASE: begin
                if (cnt_r == DEB_LAST) begin
                    cnt_nxt_s   = CNT_ZERO;
                    row_nxt_s   = row_r + 2'd1;
                    state_nxt_s = SCAN;
                end else if (col_s == 4'b1111) begin
                    cnt_nxt_s = cnt_inc_s;
                end else begin
                    cnt_nxt_s = CNT_ZERO;
                end
            end
            default: begin
                cnt_nxt_s   = CNT_ZERO;
                row_nxt_s   = 2'd0;
                state_nxt_s = SCAN;
            end
        endcase
    end

    // State, counters and registered outputs. tecla/tecla_valid are loaded
    // on entry to EMIT so they are valid during the EMIT cycle itself.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= SCAN;
            cnt_r         <= CNT_ZERO;
            row_r         <= 2'd0;
            col_idx_r     <= 2'd0;
            row_out_r     <= 4'b1110;
            tecla_r       <= 4'b0000;
            tecla_valid_r <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            cnt_r         <= cnt_nxt_s;
            row_r         <= row_nxt_s;
            col_idx_r     <= col_idx_nxt_s;
            row_out_r     <= row_drive(row_nxt_s);
            tecla_valid_r <= (state_nxt_s == EMIT);
            if (state_nxt_s == EMIT) begin
                tecla_r <= key_map(row_r, col_idx_r);
            end else begin
                tecla_r <= tecla_r;
            end
        end
    end

    assign row_out     = row_out_r;
    assign tecla       = tecla_r;
    assign tecla_valid = tecla_valid_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed self-checking bench for keypad_scanner with a behavioural 4x4
// keypad: a pressed key pulls its column low while its row is driven low.
module tb_keypad_scanner;

    localparam int SC = 4;
    localparam int DC = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  col_in;
    logic [3:0]  row_out;
    logic [3:0]  tecla;
    logic        tecla_valid;
    logic [15:0] press = 16'h0000;   // bit row*4+col = key held

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    int         pulse_cnt = 0;
    int         pulse_cyc = 0;
    int         dbl_cnt   = 0;
    logic       prev_v    = 1'b0;
    logic [3:0] pulse_log [0:63];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Keypad matrix model.
    always_comb begin
        col_in = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (press[r*4+c] && !row_out[r]) col_in[c] = 1'b0;
            end
        end
    end

    // Pulse recorder.
    always @(negedge clk) begin
        if (tecla_valid) begin
            pulse_log[pulse_cnt[5:0]] <= tecla;
            pulse_cnt <= pulse_cnt + 1;
            pulse_cyc <= cyc;
            if (prev_v) dbl_cnt <= dbl_cnt + 1;
        end
        prev_v <= tecla_valid;
    end

    keypad_scanner #(
        .SCAN_CYCLES     (SC),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .col_in      (col_in),
        .row_out     (row_out),
        .tecla       (tecla),
        .tecla_valid (tecla_valid)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Waits for row_out to change to exp; returns the cycle it was first seen.
    task automatic wait_row(input string tag, input logic [3:0] exp, input int budget, output int at);
        logic [3:0] prev;
        bit found;
        found = 1'b0;
        at = 0;
        prev = row_out;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (row_out === exp && prev !== exp) begin
                found = 1'b1;
                at = cyc;
            end
            prev = row_out;
        end
        chk(tag, 32'(found), 32'd1);
    endtask

    task automatic wait_pulse(input string tag, input int start, input int budget);
        bit found;
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (pulse_cnt > start) found = 1'b1;
        end
        chk(tag, 32'(found), 32'd1);
    endtask

    int t_a, t_b, t_c, p0, lstart;
    logic [3:0] codes [0:3];
    int         keys  [0:3];
    logic [31:0] got_code;

    initial begin
        codes[0] = 4'b0001; keys[0] = 0;    // "1"
        codes[1] = 4'b1010; keys[1] = 3;    // soma
        codes[2] = 4'b0010; keys[2] = 1;    // "2"
        codes[3] = 4'b1110; keys[3] = 14;   // enter

        // Reset state
        hold(3);
        chk("rst_row_out", 32'(row_out), 32'h0000000E);
        chk("rst_tecla", 32'(tecla), 32'd0);
        chk("rst_valid", 32'(tecla_valid), 32'd0);
        reset = 1'b1;

        // Clean press r1/c2 held 200 cycles: one pulse, fixed latency
        wait_row("t1_row0", 4'b1110, 40, t_a);
        p0 = pulse_cnt;
        press[1*4+2] = 1'b1;
        wait_row("t1_row1", 4'b1101, 20, t_a);
        wait_pulse("t1_pulse", p0, 80);
        // row change -> sample is SC+1 cycles, sample -> pulse is DC+1
        chk("t1_latency", 32'(pulse_cyc - t_a), 32'(SC + 1 + DC + 1));
        chk("t1_code", 32'(tecla), 32'h6);
        hold(170);
        chk("t1_single_while_held", 32'(pulse_cnt - p0), 32'd1);
        press = 16'h0000;
        hold(60);
        chk("t1_single_after_release", 32'(pulse_cnt - p0), 32'd1);

        // Bounce r0/c3 every 5 cycles for 60 cycles, then stable
        p0 = pulse_cnt;
        for (int k = 0; k < 12; k++) begin
            press[0*4+3] = (k % 2 == 0);
            hold(5);
        end
        chk("t2_bounce_quiet", 32'(pulse_cnt - p0), 32'd0);
        press[0*4+3] = 1'b1;
        wait_pulse("t2_pulse", p0, 80);
        chk("t2_code", 32'(tecla), 32'hA);
        hold(40);
        chk("t2_single", 32'(pulse_cnt - p0), 32'd1);
        press = 16'h0000;
        hold(60);

        // Two keys in row 2: ignored, scan keeps cycling
        p0 = pulse_cnt;
        press[2*4+0] = 1'b1;
        press[2*4+1] = 1'b1;
        wait_row("t3_row0", 4'b1110, 40, t_a);
        wait_row("t3_row1", 4'b1101, 10, t_a);
        wait_row("t3_row2", 4'b1011, 10, t_b);
        wait_row("t3_row3", 4'b0111, 10, t_c);
        chk("t3_row2_dwell", 32'(t_c - t_b), 32'(SC + 1));
        wait_row("t3_row0_again", 4'b1110, 10, t_a);
        hold(40);
        chk("t3_no_pulse", 32'(pulse_cnt - p0), 32'd0);
        press = 16'h0000;
        hold(10);

        // Sequence 1, +, 2, enter
        p0 = pulse_cnt;
        lstart = pulse_cnt;
        for (int i = 0; i < 4; i++) begin
            press[keys[i]] = 1'b1;
            hold(50);
            press = 16'h0000;
            hold(50);
        end
        chk("t4_count", 32'(pulse_cnt - p0), 32'd4);
        for (int i = 0; i < 4; i++) begin
            got_code = (lstart + i < pulse_cnt) ? 32'(pulse_log[lstart+i]) : 32'hDEAD;
            chk($sformatf("t4_code%0d", i), got_code, 32'(codes[i]));
        end

        // Reset at DEBOUNCE count 8 on r1/c1
        p0 = pulse_cnt;
        wait_row("t5_row0", 4'b1110, 40, t_a);
        press[1*4+1] = 1'b1;
        wait_row("t5_row1", 4'b1101, 10, t_a);
        hold(SC + 1 + 8);   // sample edge, then 8 matching edges
        reset = 1'b0;
        #1;
        chk("t5_rst_row_out", 32'(row_out), 32'h0000000E);
        chk("t5_rst_tecla", 32'(tecla), 32'd0);
        chk("t5_rst_valid", 32'(tecla_valid), 32'd0);
        press = 16'h0000;
        hold(3);
        reset = 1'b1;
        t_b = cyc;
        wait_row("t5_restart_row1", 4'b1101, 20, t_a);
        chk("t5_restart_timing", 32'(t_a - t_b), 32'(SC + 1));
        hold(60);
        chk("t5_no_pulse", 32'(pulse_cnt - p0), 32'd0);
        chk("t5_tecla_kept", 32'(tecla), 32'd0);

        // r3/c1 with glitches during release
        p0 = pulse_cnt;
        press[3*4+1] = 1'b1;
        wait_pulse("t6_pulse", p0, 80);
        chk("t6_code", 32'(pulse_log[p0[5:0]]), 32'd0);
        hold(10);
        press = 16'h0000;
        hold(8);
        press[3*4+1] = 1'b1;
        hold(3);
        press = 16'h0000;
        hold(8);
        press[3*4+1] = 1'b1;
        hold(3);
        press = 16'h0000;
        t_b = cyc;
        wait_row("t6_resume", 4'b1110, 60, t_a);
        // two synchronizer edges, DC counting edges, one transition edge
        chk("t6_resume_timing", 32'(t_a - t_b), 32'(DC + 3));
        hold(20);
        chk("t6_single", 32'(pulse_cnt - p0), 32'd1);

        chk("no_back_to_back", 32'(dbl_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
